// File: rtl/logic_sweep_pkg.sv
// ============================================================================
// Module   : logic_sweep_pkg
// Brief    : Shared types and constants for the truth-table sweep controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package logic_sweep_pkg;

    localparam int VEC_W   = 3;
    localparam int NUM_VEC = 8;

    // Golden table for X = A | C, bit i corresponds to vector {A,B,C} = i
    localparam logic [NUM_VEC-1:0] EXPECTED_DEFAULT = 8'hFA;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } sweep_state_t;

    function automatic logic [VEC_W-1:0] lowest_set_idx(input logic [NUM_VEC-1:0] mask);
        logic [VEC_W-1:0] idx;
        idx = '0;
        for (int i = NUM_VEC - 1; i >= 0; i--) begin
            if (mask[i]) idx = VEC_W'(i);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/logic_sweep_timer.sv
// ============================================================================
// Module   : logic_sweep_timer
// Brief    : Settle down-counter; loaded on DRIVE, expires on the last settle cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_sweep_timer
    import logic_sweep_pkg::*;
#(
    parameter int CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (load) begin
            r_cnt <= 4'(CYCLES);
        end else if (en && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign expire = en && (r_cnt == 4'd1);

endmodule

`default_nettype wire

// File: rtl/logic_sweep_ctrl.sv
// ============================================================================
// Module   : logic_sweep_ctrl
// Brief    : Sweeps all 8 {A,B,C} vectors into a combinational block and
//            compares the responses against a golden truth table.
//            Build option: SWEEP_STOP_ON_FAIL_EN ends the sweep on first mismatch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_sweep_ctrl
    import logic_sweep_pkg::*;
#(
    parameter int                 SETTLE_CYCLES = 2,
    parameter logic [NUM_VEC-1:0] EXPECTED      = EXPECTED_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               x_in,
    output logic [VEC_W-1:0]   abc_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [NUM_VEC-1:0] result,
    output logic [NUM_VEC-1:0] fail_mask,
    output logic [VEC_W-1:0]   fail_idx,
    output logic               aborted
);

`ifdef SWEEP_STOP_ON_FAIL_EN
    localparam bit c_stop_on_fail = 1'b1;
`else
    localparam bit c_stop_on_fail = 1'b0;
`endif

    sweep_state_t       r_state;
    sweep_state_t       w_state_nxt;
    logic [VEC_W-1:0]   r_idx;
    logic [VEC_W-1:0]   r_abc;
    logic               r_done;
    logic               r_pass;
    logic [NUM_VEC-1:0] r_result;
    logic [NUM_VEC-1:0] r_fail_mask;
    logic [VEC_W-1:0]   r_fail_idx;
    logic               r_aborted;
    logic               w_timer_load;
    logic               w_timer_en;
    logic               w_expire;
    logic               w_mismatch;
    logic               w_last_vec;

    logic_sweep_timer #(
        .CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (w_timer_load),
        .en     (w_timer_en),
        .expire (w_expire)
    );

    assign w_mismatch = x_in ^ EXPECTED[r_idx];
    assign w_last_vec = (r_idx == VEC_W'(NUM_VEC - 1));

    always_comb begin
        w_state_nxt  = r_state;
        w_timer_load = 1'b0;
        w_timer_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_DRIVE;
            end
            ST_DRIVE: begin
                w_timer_load = 1'b1;
                w_state_nxt  = abort ? ST_DONE : ST_SETTLE;
            end
            ST_SETTLE: begin
                w_timer_en = 1'b1;
                if (abort)         w_state_nxt = ST_DONE;
                else if (w_expire) w_state_nxt = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (abort || w_last_vec || (c_stop_on_fail && w_mismatch))
                    w_state_nxt = ST_DONE;
                else
                    w_state_nxt = ST_DRIVE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_abc       <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_result    <= '0;
            r_fail_mask <= '0;
            r_fail_idx  <= '0;
            r_aborted   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_idx       <= '0;
                        r_result    <= '0;
                        r_fail_mask <= '0;
                        r_pass      <= 1'b0;
                        r_fail_idx  <= '0;
                        r_aborted   <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    if (abort) r_aborted <= 1'b1;
                    else       r_abc     <= r_idx;
                end
                ST_SETTLE: begin
                    if (abort) r_aborted <= 1'b1;
                end
                ST_SAMPLE: begin
                    // An abort landing on the sample edge leaves that vector unsampled
                    if (abort) begin
                        r_aborted <= 1'b1;
                    end else begin
                        r_result[r_idx]    <= x_in;
                        r_fail_mask[r_idx] <= w_mismatch;
                        if (w_state_nxt == ST_DRIVE) r_idx <= r_idx + VEC_W'(1);
                    end
                end
                ST_DONE: begin
                    r_done     <= 1'b1;
                    r_pass     <= (r_fail_mask == '0) && !r_aborted;
                    r_fail_idx <= lowest_set_idx(r_fail_mask);
                end
                default: begin
                end
            endcase
        end
    end

    assign abc_out   = r_abc;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign pass      = r_pass;
    assign result    = r_result;
    assign fail_mask = r_fail_mask;
    assign fail_idx  = r_fail_idx;
    assign aborted   = r_aborted;

endmodule

`default_nettype wire

// File: doc/logic_sweep_ctrl.md
LOGIC_SWEEP_CTRL -- requirements
Module: logic_sweep_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, gives the wait cycles between driving a vector and sampling the response; legal range 1..15.
REQ-002 Parameter EXPECTED[7:0], default 8'hFA, is the golden truth table (bit i = expected x for vector i = {A,B,C}); 8'hFA encodes X = A|C.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a sweep.
REQ-006 abort  input  1  terminate a running sweep.
REQ-007 x_in  input  1  response from the combinational DUT.
REQ-008 abc_out  output  3  registered stimulus {A,B,C} to the DUT.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  one-cycle pulse at sweep completion, normal or aborted.
REQ-011 pass  output  1  high when the last completed sweep matched EXPECTED in all 8 bits.
REQ-012 result  output  8  captured x_in per vector index.
REQ-013 fail_mask  output  8  result XOR EXPECTED, per index.
REQ-014 fail_idx  output  3  lowest failing index; 0 when pass=1.
REQ-015 aborted  output  1  high when the last sweep ended by abort.

Function
REQ-016 The FSM states SHALL be IDLE, DRIVE, SETTLE, SAMPLE, DONE.
REQ-017 IDLE: start=1 -> DRIVE; vector index cleared to 0; result, fail_mask, pass, fail_idx, aborted cleared on the same edge.
REQ-018 DRIVE: abc_out <= index; -> SETTLE; lasts exactly 1 cycle.
REQ-019 SETTLE: lasts exactly SETTLE_CYCLES cycles, then -> SAMPLE.
REQ-020 SAMPLE: result[index] <= x_in, fail_mask[index] <= x_in ^ EXPECTED[index]; index 7 -> DONE, otherwise index+1 -> DRIVE.
REQ-021 DONE: done=1 for one cycle; pass = (fail_mask==0); fail_idx = lowest set bit of fail_mask; -> IDLE.
REQ-022 Per-vector latency SHALL be SETTLE_CYCLES+2 cycles; done SHALL assert 8*(SETTLE_CYCLES+2)+1 cycles after the edge that samples start (33 cycles at default).
REQ-023 busy SHALL be 1 in DRIVE, SETTLE, SAMPLE, DONE and 0 in IDLE.
REQ-024 start while busy SHALL be ignored; no restart, no state change.
REQ-025 abort in any non-IDLE state except DONE SHALL move to DONE on the next edge with aborted=1, pass=0; unsampled result/fail_mask bits remain 0.
REQ-026 abort and start asserted together in IDLE: start wins, abort ignored.
REQ-027 abc_out SHALL hold its last value between sweeps.
REQ-028 Index SHALL not wrap; 7 is terminal.

Reset
REQ-029 rst=1 SHALL, on the next edge, force IDLE, abc_out=3'b000, busy=0, done=0, pass=0, result=0, fail_mask=0, fail_idx=0, aborted=0, index=0, settle counter=0.
REQ-030 rst mid-sweep SHALL discard the sweep without a done pulse; rst overrides start and abort.

Configuration
REQ-031 Macro SWEEP_STOP_ON_FAIL_EN defined: a SAMPLE with a mismatch SHALL go directly to DONE (pass=0, fail_idx = that index, aborted=0).
REQ-032 Macro undefined: all 8 vectors SHALL always be swept regardless of mismatches.

Structure
REQ-033 Package logic_sweep_pkg SHALL hold the state enum, VEC_W=3, NUM_VEC=8, and the default EXPECTED constant.
REQ-034 Sub-module logic_sweep_timer SHALL implement the SETTLE down-counter (load, count, expire pulse); the rest stays in logic_sweep_ctrl.

Verification
REQ-035 Default params, ideal DUT (x_in = A|C), start pulse -> abc_out steps 0..7, done at cycle 33, result=8'hFA, fail_mask=0, pass=1.
REQ-036 x_in stuck at 0 -> result=8'h00, fail_mask=8'hFA, fail_idx=1, pass=0; with SWEEP_STOP_ON_FAIL_EN, done after vector 1, result=8'h00, fail_idx=1.
REQ-037 abort asserted during SETTLE of vector 3 -> done next cycle, aborted=1, pass=0, result bits 7:3 = 0.
REQ-038 start re-pulsed at cycle 10 of a sweep -> ignored; single done at cycle 33.
REQ-039 rst asserted during vector 5 -> all outputs at reset values next cycle, no done pulse; a following start runs a full clean sweep.
REQ-040 SETTLE_CYCLES=1 and 15 -> done at cycles 25 and 137 respectively, pass=1 with ideal DUT.
